// File: rtl/masked_rmw_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : masked_rmw_ctrl
// Purpose  : Byte-masked read-modify-write controller around a DEPTH x 32-bit
//            register array. Each accepted request returns the pre-write word
//            one cycle later and writes back the byte-merged word. A same-address
//            request accepted right behind a write sees the merged value through
//            a stage-2 bypass. A zero-fill sweep runs after reset and on io_clear.
// Ports    : clk           - clock, all state on rising edge
//            reset         - synchronous active-low reset
//            io_req_*      - request handshake (valid/ready), addr, data, mask
//            io_clear      - pulse requesting a zero-fill of every entry
//            io_resp_valid - one-cycle pulse per accepted request
//            io_resp_data  - entry value before the request's write (held)
//            io_busy       - sweep in progress or stage 2 occupied
//            io_wr_count   - saturating count of accepted nonzero-mask requests
// Revision : 1.0 - initial release
// ============================================================================
module masked_rmw_ctrl #(
   parameter int DEPTH = 8,
   parameter int CNT_W = 16
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     io_req_valid,
   output logic                     io_req_ready,
   input  logic [$clog2(DEPTH)-1:0] io_req_addr,
   input  logic [31:0]              io_req_data,
   input  logic [3:0]               io_req_mask,
   input  logic                     io_clear,
   output logic                     io_resp_valid,
   output logic [31:0]              io_resp_data,
   output logic                     io_busy,
   output logic [CNT_W-1:0]         io_wr_count
);

   localparam int c_ADDR_W = $clog2(DEPTH);
   localparam logic [c_ADDR_W-1:0] c_LAST_IDX = c_ADDR_W'(DEPTH - 1);
   localparam logic [CNT_W-1:0]    c_CNT_MAX  = {CNT_W{1'b1}};

   typedef enum logic [0:0] {
      ST_CLEAR = 1'b0,
      ST_IDLE  = 1'b1
   } state_t;

   state_t              r_state;
   logic [c_ADDR_W-1:0] r_clr_idx;
   logic                r_s2_valid;
   logic [c_ADDR_W-1:0] r_s2_addr;
   logic [31:0]         r_s2_data;
   logic [3:0]          r_s2_mask;
   logic [31:0]         r_s2_old;
   logic [CNT_W-1:0]    r_wr_count;
   logic [31:0]         r_mem [DEPTH];

   logic                w_ready;
   logic                w_accept;
   logic                w_s2_write;
   logic [31:0]         w_merged;
   logic [31:0]         w_old;

   always_comb begin
      w_merged = r_s2_old;
      for (int i = 0; i < 4; i++) begin
         if (r_s2_mask[i]) begin
            w_merged[8*i +: 8] = r_s2_data[8*i +: 8];
         end
      end
   end

   assign w_s2_write = r_s2_valid && (r_s2_mask != 4'h0);
   assign w_ready    = (r_state == ST_IDLE) && !io_clear;
   assign w_accept   = io_req_valid && w_ready;

   // The array is only updated at the end of stage 2, so a same-address
   // request in stage 1 must take the merged word straight from stage 2.
   assign w_old = (w_s2_write && (r_s2_addr == io_req_addr)) ? w_merged
                                                            : r_mem[io_req_addr];

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state    <= ST_CLEAR;
         r_clr_idx  <= '0;
         r_s2_valid <= 1'b0;
         r_s2_old   <= '0;
         r_wr_count <= '0;
      end else begin
         case (r_state)
            ST_CLEAR: begin
               r_clr_idx <= r_clr_idx + c_ADDR_W'(1);
               if (r_clr_idx == c_LAST_IDX) begin
                  r_state <= ST_IDLE;
               end
            end
            ST_IDLE: begin
               if (io_clear) begin
                  r_state   <= ST_CLEAR;
                  r_clr_idx <= '0;
               end
            end
            default: r_state <= ST_CLEAR;
         endcase

         r_s2_valid <= w_accept;
         if (w_accept) begin
            r_s2_addr <= io_req_addr;
            r_s2_data <= io_req_data;
            r_s2_mask <= io_req_mask;
            r_s2_old  <= w_old;
            if ((io_req_mask != 4'h0) && (r_wr_count != c_CNT_MAX)) begin
               r_wr_count <= r_wr_count + CNT_W'(1);
            end
         end
      end
   end

   // The clear write is issued after the stage-2 write so that it wins when
   // both target the same entry in the first sweep cycle. Nothing is written
   // while reset is low, which discards any in-flight stage-2 write.
   always_ff @(posedge clk) begin
      if (reset) begin
         if (w_s2_write) begin
            r_mem[r_s2_addr] <= w_merged;
         end
         if (r_state == ST_CLEAR) begin
            r_mem[r_clr_idx] <= '0;
         end
      end
   end

   // Outputs are forced to their reset values while reset is held low.
   assign io_req_ready  = reset && w_ready;
   assign io_resp_valid = reset && r_s2_valid;
   assign io_resp_data  = reset ? r_s2_old : 32'h0;
   assign io_busy       = !reset || (r_state == ST_CLEAR) || r_s2_valid;
   assign io_wr_count   = reset ? r_wr_count : '0;

endmodule
`default_nettype wire

// File: tb/tb_masked_rmw_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_masked_rmw_ctrl
// Purpose  : Self-checking bench for masked_rmw_ctrl (DEPTH=8, CNT_W=4).
//            A sequential memory model answers every request in program order;
//            the controller's pipelining and bypass must be invisible to it.
// Revision : 1.0 - initial release
// ============================================================================
module tb_masked_rmw_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic        io_req_valid;
   logic        io_req_ready;
   logic [2:0]  io_req_addr;
   logic [31:0] io_req_data;
   logic [3:0]  io_req_mask;
   logic        io_clear;
   logic        io_resp_valid;
   logic [31:0] io_resp_data;
   logic        io_busy;
   logic [3:0]  io_wr_count;

   always #5 clk = ~clk;

   masked_rmw_ctrl #(.DEPTH(8), .CNT_W(4)) dut (
      .clk           (clk),
      .reset         (reset),
      .io_req_valid  (io_req_valid),
      .io_req_ready  (io_req_ready),
      .io_req_addr   (io_req_addr),
      .io_req_data   (io_req_data),
      .io_req_mask   (io_req_mask),
      .io_clear      (io_clear),
      .io_resp_valid (io_resp_valid),
      .io_resp_data  (io_resp_data),
      .io_busy       (io_busy),
      .io_wr_count   (io_wr_count)
   );

   int checks = 0;
   int errors = 0;

   // reference model state
   logic [31:0] m_mem [8];
   int          m_left;     // remaining sweep cycles
   int          m_cnt;
   bit          m_pend;     // a response is due this cycle
   logic [31:0] m_resp;
   logic [31:0] m_last;     // value io_resp_data must hold
   logic [31:0] obs_last;   // last observed response word
   bit          last_acc;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 8; i++) m_mem[i] = 32'h0;
      m_left = 8;
      m_cnt  = 0;
      m_pend = 1'b0;
      m_last = 32'h0;
   endtask

   // One clock cycle, entered and left at a falling edge.
   task automatic cyc(input bit v, input logic [2:0] a, input logic [31:0] d,
                      input logic [3:0] m, input bit c);
      bit rdy;
      chk("busy", {31'h0, io_busy}, {31'h0, (m_left > 0) || m_pend});
      chk("wr_count", {28'h0, io_wr_count}, 32'(m_cnt));
      if (m_pend) begin
         chk("resp_valid", {31'h0, io_resp_valid}, 32'h1);
         chk("resp_data", io_resp_data, m_resp);
         m_last   = m_resp;
         obs_last = io_resp_data;
      end else begin
         chk("resp_valid_idle", {31'h0, io_resp_valid}, 32'h0);
         chk("resp_hold", io_resp_data, m_last);
      end
      io_req_valid = v;
      io_req_addr  = a;
      io_req_data  = d;
      io_req_mask  = m;
      io_clear     = c;
      #1;
      rdy = (m_left == 0) && !c;
      chk("req_ready", {31'h0, io_req_ready}, {31'h0, rdy});
      last_acc = v && rdy;
      m_pend   = last_acc;
      if (last_acc) begin
         m_resp = m_mem[a];
         for (int i = 0; i < 4; i++)
            if (m[i]) m_mem[a][8*i +: 8] = d[8*i +: 8];
         if (m != 4'h0 && m_cnt < 15) m_cnt++;
      end
      if (m_left > 0) m_left--;
      else if (c) begin
         m_left = 8;
         for (int i = 0; i < 8; i++) m_mem[i] = 32'h0;
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(1'b0, 3'd0, 32'h0, 4'h0, 1'b0);
   endtask

   // Present a request until accepted (bounded); n returns cycles used.
   task automatic req(input logic [2:0] a, input logic [31:0] d,
                      input logic [3:0] m, output int n);
      n = 0;
      do begin
         cyc(1'b1, a, d, m, 1'b0);
         n++;
      end while (!last_acc && n < 20);
      chk("req_accepted", {31'h0, last_acc}, 32'h1);
   endtask

   initial begin
      int n;
      int cnt_before;
      logic [31:0] rd;
      reset        = 1'b0;
      io_req_valid = 1'b0;
      io_req_addr  = 3'd0;
      io_req_data  = 32'h0;
      io_req_mask  = 4'h0;
      io_clear     = 1'b0;
      obs_last     = 32'h0;
      model_reset();

      // outputs while reset is held
      @(negedge clk);
      chk("rst_ready", {31'h0, io_req_ready}, 32'h0);
      chk("rst_resp_valid", {31'h0, io_resp_valid}, 32'h0);
      chk("rst_resp_data", io_resp_data, 32'h0);
      chk("rst_busy", {31'h0, io_busy}, 32'h1);
      chk("rst_wr_count", {28'h0, io_wr_count}, 32'h0);
      @(negedge clk);
      reset = 1'b1;
      model_reset();

      // read every entry after the reset sweep
      req(3'd0, 32'h0, 4'h0, n);
      chk("first_ready_cycle", 32'(n), 32'd9);
      for (int i = 1; i < 8; i++) req(3'(i), 32'h0, 4'h0, n);
      idle(1);

      // masked read-modify-write on entry 3
      req(3'd3, 32'hAABBCCDD, 4'hF, n);
      req(3'd3, 32'h11223344, 4'b0101, n);
      req(3'd3, 32'h0, 4'h0, n);
      idle(1);
      chk("rmw_read_addr3", obs_last, 32'hAA22CC44);

      // back-to-back same-address writes through the bypass
      req(3'd5, 32'h000000EE, 4'h1, n);
      req(3'd5, 32'h0000FF00, 4'h2, n);
      req(3'd5, 32'h0, 4'h0, n);
      idle(1);
      chk("bypass_read_addr5", obs_last, 32'h0000FFEE);

      // fill with nonzero data, then clear with a colliding request
      for (int i = 0; i < 8; i++) req(3'(i), $urandom | 32'h1, 4'hF, n);
      cnt_before = m_cnt;
      cyc(1'b1, 3'd1, 32'hDEADBEEF, 4'hF, 1'b1);
      idle(8);
      req(3'd0, 32'h0, 4'h0, n);
      chk("post_clear_ready_cycle", 32'(n), 32'd1);
      for (int i = 1; i < 8; i++) req(3'(i), 32'h0, 4'h0, n);
      idle(1);
      chk("clear_read_zero", obs_last, 32'h0);
      chk("count_after_clear", {28'h0, io_wr_count}, 32'(cnt_before));

      // reset during stage 2 of a write to entry 2
      req(3'd2, 32'h12345678, 4'hF, n);
      io_req_valid = 1'b0;
      reset = 1'b0;
      #1;
      chk("rst_s2_resp_valid", {31'h0, io_resp_valid}, 32'h0);
      chk("rst_s2_busy", {31'h0, io_busy}, 32'h1);
      @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      model_reset();
      idle(8);
      req(3'd2, 32'h0, 4'h0, n);
      idle(1);
      chk("rst_s2_entry2_zero", obs_last, 32'h0);

      // counter saturation: 20 writes and 5 reads
      for (int i = 0; i < 25; i++) begin
         if (i % 5 == 4) req(3'($urandom_range(0, 7)), 32'h0, 4'h0, n);
         else req(3'($urandom_range(0, 7)), $urandom, 4'($urandom_range(1, 15)), n);
      end
      idle(1);
      chk("wr_count_saturated", {28'h0, io_wr_count}, 32'hF);

      // random traffic, biased toward few addresses to exercise the bypass
      for (int i = 0; i < 300; i++) begin
         rd = $urandom;
         cyc(rd[1:0] != 2'b00,
             rd[2] ? 3'($urandom_range(0, 1)) : 3'($urandom_range(0, 7)),
             $urandom,
             rd[3] ? 4'h0 : 4'($urandom),
             ($urandom_range(0, 39) == 0));
      end
      idle(10);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire
